// File: rtl/pwm_duty_feeder.sv
// Sample FIFO and duty-word generator feeding the PWM_MarkI Dato input on period boundaries.
// Optional build macro DUTY_HOLD_ON_UNDERRUN_EN: keep the last duty word (no load pulse) on an underrun tick.
module pwm_duty_feeder #(
    parameter int DATA_W      = 22,
    parameter int FIFO_DEPTH  = 8,
    parameter int PRIME_LEVEL = 4,
    parameter int DUTY_MAX    = 4194303
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          period_tick,
    output logic [DATA_W-1:0]             duty,
    output logic                          duty_load,
    output logic                          underrun,
    input  logic                          clear_underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]       FULL_LVL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]       PRIME_LVL = (AW+1)'(PRIME_LEVEL);
    localparam logic [DATA_W-1:0] DMAX      = DATA_W'(DUTY_MAX);
    localparam logic [DATA_W-1:0] HALF      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MIDSCALE  = (HALF > DMAX) ? DMAX : HALF;

`ifdef DUTY_HOLD_ON_UNDERRUN_EN
    localparam bit HOLD_ON_UNDERRUN = 1'b1;
`else
    localparam bit HOLD_ON_UNDERRUN = 1'b0;
`endif

    localparam logic [1:0] ST_PRIME   = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_STARVED = 2'd2;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [1:0]        state;
    logic              push;
    logic              pop;
    logic              starve_evt;
    logic              primed;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] duty_next;

    assign sample_ready = (fifo_level != FULL_LVL);
    assign push         = sample_valid && sample_ready;
    assign pop          = (state == ST_RUN) && period_tick && (fifo_level != '0);
    assign starve_evt   = (state == ST_RUN) && period_tick && (fifo_level == '0);
    assign primed       = (fifo_level >= PRIME_LVL);

    // Signed sample becomes offset binary by flipping the MSB, then clamps to DUTY_MAX.
    assign head      = mem[rd_ptr];
    assign offset    = {~head[DATA_W-1], head[DATA_W-2:0]};
    assign duty_next = (offset > DMAX) ? DMAX : offset;

    // Storage needs no reset: the pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_PRIME;
        end else begin
            case (state)
                ST_PRIME, ST_STARVED: if (primed) state <= ST_RUN;
                ST_RUN:               if (starve_evt) state <= ST_STARVED;
                default:              state <= ST_PRIME;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty      <= MIDSCALE;
            duty_load <= 1'b0;
        end else begin
            duty_load <= 1'b0;
            if (pop) begin
                duty      <= duty_next;
                duty_load <= 1'b1;
            end else if (starve_evt && !HOLD_ON_UNDERRUN) begin
                duty      <= MIDSCALE;
                duty_load <= 1'b1;
            end
        end
    end

    // A new underrun in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (starve_evt) begin
            underrun <= 1'b1;
        end else if (clear_underrun) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_duty_feeder.sv
// Scoreboard bench for pwm_duty_feeder: default instance plus a clamped instance (DUTY_MAX=1000).
module tb_pwm_duty_feeder;

    localparam int          DMAX1 = 4194303;
    localparam int          DMAX2 = 1000;
    localparam logic [21:0] MID   = 22'h200000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [21:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        period_tick = 1'b0;
    logic        clear_underrun = 1'b0;
    logic        sample_valid2 = 1'b0;
    logic        period_tick2 = 1'b0;

    logic        sample_ready, duty_load, underrun;
    logic [21:0] duty;
    logic [3:0]  fifo_level;
    logic        sample_ready2, duty_load2, underrun2;
    logic [21:0] duty2;
    logic [3:0]  fifo_level2;

    int          checks = 0;
    int          failures = 0;
    int          loads = 0;
    logic [21:0] exp_q[$];
    logic [21:0] exp_q2[$];
    logic [21:0] sb_exp;
    logic [21:0] sb_exp2;

    pwm_duty_feeder dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .period_tick(period_tick), .duty(duty),
        .duty_load(duty_load), .underrun(underrun), .clear_underrun(clear_underrun),
        .fifo_level(fifo_level)
    );

    pwm_duty_feeder #(.PRIME_LEVEL(1), .DUTY_MAX(DMAX2)) dut2 (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid2),
        .sample_ready(sample_ready2), .period_tick(period_tick2), .duty(duty2),
        .duty_load(duty_load2), .underrun(underrun2), .clear_underrun(clear_underrun),
        .fifo_level(fifo_level2)
    );

    always #5 clk = ~clk;

    // Reference conversion done arithmetically: add half range modulo 2^22, then clamp.
    function automatic logic [21:0] conv(input logic [21:0] s, input int dmax);
        logic [22:0] off;
        off = ({1'b0, s} + 23'h200000) & 23'h3FFFFF;
        if (off > 23'(dmax)) return 22'(dmax);
        return off[21:0];
    endfunction

    always @(negedge clk) begin
        if (duty_load === 1'b1) begin
            loads++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_duty unexpected load, duty=%h", duty);
            end else begin
                sb_exp = exp_q.pop_front();
                if (duty !== sb_exp) begin
                    failures++;
                    $display("FAIL sb_duty got=%h expected=%h", duty, sb_exp);
                end
            end
        end
        if (duty_load2 === 1'b1) begin
            checks++;
            if (exp_q2.size() == 0) begin
                failures++;
                $display("FAIL sb_duty2 unexpected load, duty2=%h", duty2);
            end else begin
                sb_exp2 = exp_q2.pop_front();
                if (duty2 !== sb_exp2) begin
                    failures++;
                    $display("FAIL sb_duty2 got=%h expected=%h", duty2, sb_exp2);
                end
            end
        end
    end

    task automatic push_sample(input logic [21:0] s);
        @(negedge clk);
        sample_in    = s;
        sample_valid = 1'b1;
        exp_q.push_back(conv(s, DMAX1));
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_tick(input bit with_push, input logic [21:0] s, input bit clr,
                              output logic ld, output logic [21:0] d);
        @(negedge clk);
        period_tick    = 1'b1;
        clear_underrun = clr;
        if (with_push) begin
            sample_in    = s;
            sample_valid = 1'b1;
            exp_q.push_back(conv(s, DMAX1));
        end
        @(negedge clk);
        period_tick    = 1'b0;
        clear_underrun = 1'b0;
        sample_valid   = 1'b0;
        ld = duty_load;
        d  = duty;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (duty !== MID) begin failures++; $display("FAIL reset_duty got=%h expected=%h", duty, MID); end
        checks++; if (duty_load !== 1'b0) begin failures++; $display("FAIL reset_load got=%b expected=0", duty_load); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b expected=0", underrun); end
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d expected=0", fifo_level); end
        checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b expected=1", sample_ready); end
        checks++; if (duty2 !== 22'd1000) begin failures++; $display("FAIL reset_duty2 got=%0d expected=1000", duty2); end
    endtask

    task automatic test_clamp();
        logic [21:0] vals [2];
        logic [21:0] e;
        vals[0] = 22'h2001F4;
        vals[1] = 22'h000000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sample_in     = vals[i];
            sample_valid2 = 1'b1;
            e = conv(vals[i], DMAX2);
            exp_q2.push_back(e);
            @(negedge clk);
            sample_valid2 = 1'b0;
            @(negedge clk);
            period_tick2 = 1'b1;
            @(negedge clk);
            period_tick2 = 1'b0;
            checks++; if (duty_load2 !== 1'b1) begin failures++; $display("FAIL clamp_load%0d got=%b expected=1", i, duty_load2); end
            checks++; if (duty2 !== e) begin failures++; $display("FAIL clamp_duty%0d got=%0d expected=%0d", i, duty2, e); end
        end
    endtask

    task automatic test_prime();
        logic ld;
        logic [21:0] d;
        push_sample(22'h000000);
        push_sample(22'h3FFFFF);
        push_sample(22'h1FFFFF);
        for (int i = 0; i < 2; i++) begin
            pulse_tick(1'b0, '0, 1'b0, ld, d);
            checks++; if (ld !== 1'b0) begin failures++; $display("FAIL prime_load%0d got=%b expected=0", i, ld); end
            checks++; if (d !== MID) begin failures++; $display("FAIL prime_duty%0d got=%h expected=%h", i, d, MID); end
        end
        checks++; if (fifo_level !== 4'd3) begin failures++; $display("FAIL prime_level got=%0d expected=3", fifo_level); end
        checks++; if (loads !== 0) begin failures++; $display("FAIL prime_loads got=%0d expected=0", loads); end
    endtask

    task automatic test_run();
        logic ld;
        logic [21:0] d;
        logic [21:0] seq [4];
        seq[0] = 22'h200000; seq[1] = 22'h1FFFFF; seq[2] = 22'h3FFFFF; seq[3] = 22'h000000;
        push_sample(22'h200000);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            repeat (19) @(negedge clk);
            pulse_tick(1'b0, '0, 1'b0, ld, d);
            checks++; if (ld !== 1'b1) begin failures++; $display("FAIL run_load%0d got=%b expected=1", i, ld); end
            checks++; if (d !== seq[i]) begin failures++; $display("FAIL run_duty%0d got=%h expected=%h", i, d, seq[i]); end
        end
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL run_level got=%0d expected=0", fifo_level); end
        checks++; if (loads !== 4) begin failures++; $display("FAIL run_loads got=%0d expected=4", loads); end
    endtask

    task automatic test_underrun();
        logic ld;
        logic exp_ld;
        logic [21:0] d;
        logic [21:0] exp_d;
`ifdef DUTY_HOLD_ON_UNDERRUN_EN
        exp_ld = 1'b0;
        exp_d  = duty;
`else
        exp_ld = 1'b1;
        exp_d  = MID;
        exp_q.push_back(MID);
`endif
        pulse_tick(1'b0, '0, 1'b0, ld, d);
        checks++; if (ld !== exp_ld) begin failures++; $display("FAIL underrun_load got=%b expected=%b", ld, exp_ld); end
        checks++; if (d !== exp_d) begin failures++; $display("FAIL underrun_duty got=%h expected=%h", d, exp_d); end
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_flag got=%b expected=1", underrun); end
        pulse_tick(1'b0, '0, 1'b0, ld, d);
        checks++; if (ld !== 1'b0) begin failures++; $display("FAIL starved_load got=%b expected=0", ld); end
        checks++; if (d !== exp_d) begin failures++; $display("FAIL starved_duty got=%h expected=%h", d, exp_d); end
        @(negedge clk); clear_underrun = 1'b1;
        @(negedge clk); clear_underrun = 1'b0;
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL clear_flag got=%b expected=0", underrun); end
        push_sample(22'h0000FF);
        push_sample(22'h3FFF00);
        push_sample(22'h155555);
        push_sample(22'h2AAAAA);
        for (int i = 0; i < 4; i++) begin
            pulse_tick(1'b0, '0, 1'b0, ld, d);
            checks++; if (ld !== 1'b1) begin failures++; $display("FAIL resume_load%0d got=%b expected=1", i, ld); end
        end
`ifndef DUTY_HOLD_ON_UNDERRUN_EN
        exp_q.push_back(MID);
`endif
        pulse_tick(1'b0, '0, 1'b1, ld, d);
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL set_wins got=%b expected=1", underrun); end
        @(negedge clk); clear_underrun = 1'b1;
        @(negedge clk); clear_underrun = 1'b0;
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL clear_again got=%b expected=0", underrun); end
    endtask

    task automatic test_back_to_back();
        logic ld;
        logic [21:0] d;
        logic [21:0] s;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s = 22'($urandom);
            sample_in    = s;
            sample_valid = 1'b1;
            exp_q.push_back(conv(s, DMAX1));
        end
        @(negedge clk);
        sample_valid = 1'b0;
        checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL full_level got=%0d expected=8", fifo_level); end
        checks++; if (sample_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b expected=0", sample_ready); end
        @(negedge clk); sample_in = 22'h123456; sample_valid = 1'b1;
        @(negedge clk); sample_valid = 1'b0;
        checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL full_reject got=%0d expected=8", fifo_level); end
        pulse_tick(1'b0, '0, 1'b0, ld, d);
        checks++; if (fifo_level !== 4'd7) begin failures++; $display("FAIL pop_level got=%0d expected=7", fifo_level); end
        pulse_tick(1'b1, 22'h0ABCDE, 1'b0, ld, d);
        checks++; if (fifo_level !== 4'd7) begin failures++; $display("FAIL pushpop_level got=%0d expected=7", fifo_level); end
        checks++; if (ld !== 1'b1) begin failures++; $display("FAIL pushpop_load got=%b expected=1", ld); end
        push_sample(22'h3C0FFE);
        checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL refill_level got=%0d expected=8", fifo_level); end
        for (int i = 0; i < 8; i++) begin
            pulse_tick(1'b0, '0, 1'b0, ld, d);
        end
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL drain_level got=%0d expected=0", fifo_level); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL drain_queue got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_reset_midstream();
        logic ld;
        logic [21:0] d;
`ifndef DUTY_HOLD_ON_UNDERRUN_EN
        exp_q.push_back(MID);
`endif
        pulse_tick(1'b0, '0, 1'b0, ld, d);
        for (int i = 0; i < 5; i++) begin
            push_sample(22'(32'h1000 * (i + 1)));
        end
        checks++; if (fifo_level !== 4'd5) begin failures++; $display("FAIL mid_level got=%0d expected=5", fifo_level); end
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL mid_flag got=%b expected=1", underrun); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL async_level got=%0d expected=0", fifo_level); end
        checks++; if (duty !== MID) begin failures++; $display("FAIL async_duty got=%h expected=%h", duty, MID); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL async_flag got=%b expected=0", underrun); end
        checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL async_ready got=%b expected=1", sample_ready); end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] starting pwm_duty_feeder bench");
        test_reset();
        test_clamp();
        test_reset();
        test_prime();
        test_run();
        test_underrun();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
